direcc_xy_escalado: RTL and testbench

//  Parametrised, sequential successor of the VGA pixel-address generator. Sits between the
//  VGA sync counters (Columnas/Filas) and the image ROM/RAM. Produces the image address

---
 rtl/direcc_xy_escalado_pkg.sv | 41 ++++
 rtl/direcc_xy_escalado_if.sv | 24 ++
 rtl/direcc_xy_escalado_escala_cnt.sv | 56 +++++
 rtl/direcc_xy_escalado.sv | 117 +++++++++++
 tb/tb_direcc_xy_escalado.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/direcc_xy_escalado_pkg.sv
// Shared constants for the scaled VGA pixel-address generator: sync timing,
// default image size, scale codes and addressing-mode selectors.
package direcc_xy_escalado_pkg;

   localparam int H_BP_DEF  = 216;
   localparam int V_BP_DEF  = 35;
   localparam int IMG_W_DEF = 320;
   localparam int IMG_H_DEF = 240;

   typedef enum logic [1:0] {
      ESC_X1  = 2'd0,
      ESC_X2  = 2'd1,
      ESC_X4  = 2'd2,
      ESC_RSV = 2'd3
   } escala_e;

   localparam bit PACK = 1'b0;
   localparam bit LIN  = 1'b1;

   // Scale is carried as log2(S) so window ends become shifted constants.
   function automatic logic [1:0] escala_shift(input logic [1:0] sel);
      logic [1:0] sh;
      case (escala_e'(sel))
         ESC_X1:  sh = 2'd0;
         ESC_X4:  sh = 2'd2;
         default: sh = 2'd1;
      endcase
      return sh;
   endfunction

   function automatic logic [1:0] escala_last(input logic [1:0] sh);
      logic [1:0] last;
      case (sh)
         2'd0:    last = 2'd0;
         2'd1:    last = 2'd1;
         default: last = 2'd3;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/direcc_xy_escalado_if.sv
// Sync-counter inputs and image-memory address outputs of the address generator.
interface direcc_xy_escalado_if #(
   parameter int COL_W  = 11,
   parameter int ROW_W  = 10,
   parameter int ADDR_W = 17
);
   logic              pix_en;
   logic [COL_W-1:0]  Columnas;
   logic [ROW_W-1:0]  Filas;
   logic [1:0]        scale_sel;
   logic [ADDR_W-1:0] Address;
   logic              addr_valid;
   logic              frame_start;

   modport master (
      output pix_en, Columnas, Filas, scale_sel,
      input  Address, addr_valid, frame_start
   );

   modport slave (
      input  pix_en, Columnas, Filas, scale_sel,
      output Address, addr_valid, frame_start
   );
endinterface

// File: rtl/direcc_xy_escalado_escala_cnt.sv
// One axis: pre-scaler that divides ticks by S, feeding a saturating image counter.
// LOOKAHEAD=1 presents the value being loaded this tick instead of the stored one.
module escala_cnt
   import direcc_xy_escalado_pkg::*;
#(
   parameter int MAX       = 319,
   parameter int CNT_W     = 9,
   parameter bit LOOKAHEAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [1:0]       S,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);
   logic [1:0]       sub_q, sub_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_max;

   assign at_max = (cnt_q == CNT_W'(MAX));

   always_comb begin
      sub_d = sub_q;
      cnt_d = cnt_q;
      wrap  = 1'b0;
      if (clr) begin
         sub_d = '0;
         cnt_d = '0;
      end else if (en) begin
         // >= rather than == so a leftover sub count from a larger scale still wraps
         if (sub_q >= escala_last(S)) begin
            sub_d = '0;
            if (!at_max) begin
               cnt_d = cnt_q + CNT_W'(1);
               wrap  = 1'b1;
            end
         end else begin
            sub_d = sub_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q <= '0;
         cnt_q <= '0;
      end else begin
         sub_q <= sub_d;
         cnt_q <= cnt_d;
      end
   end

   assign cnt = LOOKAHEAD ? cnt_d : cnt_q;
endmodule

// File: rtl/direcc_xy_escalado.sv
// Incremental image-address generator behind the VGA sync counters: x1/x2/x4 scaling,
// linear or packed {y,x} addressing, window-valid flag and frame-start pulse.
module direcc_xy_escalado
   import direcc_xy_escalado_pkg::*;
#(
   parameter int COL_W  = 11,
   parameter int ROW_W  = 10,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_BP   = V_BP_DEF,
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int X_BITS = 9,
   parameter int Y_BITS = 8,
   parameter int ADDR_W = 17,
   parameter bit LINEAR = PACK
) (
   input logic                 clk,
   input logic                 rst_n,
   direcc_xy_escalado_if.slave bus
);
   localparam int XC_W = $clog2(IMG_W);
   localparam int YC_W = $clog2(IMG_H);

   localparam logic [COL_W-1:0] H_FIRST = COL_W'(H_BP);
   localparam logic [COL_W-1:0] H_END1  = COL_W'(H_BP + IMG_W - 1);
   localparam logic [COL_W-1:0] H_END2  = COL_W'(H_BP + (IMG_W << 1) - 1);
   localparam logic [COL_W-1:0] H_END4  = COL_W'(H_BP + (IMG_W << 2) - 1);
   localparam logic [ROW_W-1:0] V_FIRST = ROW_W'(V_BP);
   localparam logic [ROW_W-1:0] V_END1  = ROW_W'(V_BP + IMG_H - 1);
   localparam logic [ROW_W-1:0] V_END2  = ROW_W'(V_BP + (IMG_H << 1) - 1);
   localparam logic [ROW_W-1:0] V_END4  = ROW_W'(V_BP + (IMG_H << 2) - 1);

   logic [1:0]        sh_q;
   logic              armed_q, valid_q, fs_q;
   logic [ADDR_W-1:0] row_base_q, addr_q, addr_d;
   logic              valid_d;
   logic [COL_W-1:0]  h_end;
   logic [ROW_W-1:0]  v_end;
   logic              origin, col_in, row_in, line_end;
   logic [XC_W-1:0]   x_img;
   logic [YC_W-1:0]   y_img;
   logic              y_step, x_step_unused;
   logic [X_BITS+Y_BITS-1:0] packed_addr;

   always_comb begin
      h_end = H_END1;
      v_end = V_END1;
      case (sh_q)
         2'd0: begin h_end = H_END1; v_end = V_END1; end
         2'd1: begin h_end = H_END2; v_end = V_END2; end
         default: begin h_end = H_END4; v_end = V_END4; end
      endcase
   end

   assign origin   = (bus.Columnas == '0) && (bus.Filas == '0);
   assign col_in   = (bus.Columnas >= H_FIRST) && (bus.Columnas <= h_end);
   assign row_in   = (bus.Filas >= V_FIRST) && (bus.Filas <= v_end);
   assign line_end = row_in && (bus.Columnas == h_end);

   // X uses the value loaded this tick so column H_BP already addresses x=0.
   escala_cnt #(.MAX(IMG_W - 1), .CNT_W(XC_W), .LOOKAHEAD(1'b1)) u_cnt_x (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.pix_en && col_in),
      .clr   (bus.pix_en && (bus.Columnas == H_FIRST)),
      .S     (sh_q),
      .cnt   (x_img),
      .wrap  (x_step_unused)
   );

   // Y advances after the last column of a line, so the current line keeps its y.
   escala_cnt #(.MAX(IMG_H - 1), .CNT_W(YC_W), .LOOKAHEAD(1'b0)) u_cnt_y (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.pix_en && line_end),
      .clr   (bus.pix_en && origin),
      .S     (sh_q),
      .cnt   (y_img),
      .wrap  (y_step)
   );

   assign valid_d     = armed_q && col_in && row_in;
   assign packed_addr = {Y_BITS'(y_img), X_BITS'(x_img)};

   always_comb begin
      addr_d = '0;
      if (valid_d) begin
         addr_d = LINEAR ? (row_base_q + ADDR_W'(x_img)) : ADDR_W'(packed_addr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q       <= 2'd0;
         armed_q    <= 1'b0;
         row_base_q <= '0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         fs_q       <= 1'b0;
      end else if (bus.pix_en) begin
         fs_q    <= origin;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         if (origin) begin
            sh_q       <= escala_shift(bus.scale_sel);
            armed_q    <= 1'b1;
            row_base_q <= '0;
         end else if (y_step) begin
            row_base_q <= row_base_q + ADDR_W'(IMG_W);
         end
      end
   end

   assign bus.Address     = addr_q;
   assign bus.addr_valid  = valid_q;
   assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_direcc_xy_escalado.sv
// Bench for direcc_xy_escalado: linear and packed instances share one stimulus stream,
// checked against an arithmetic model every tick plus absolute table vectors.
module tb_direcc_xy_escalado;
   import direcc_xy_escalado_pkg::*;

   localparam int H_BP   = 216;
   localparam int V_BP   = 35;
   localparam int IMG_W  = 320;
   localparam int IMG_H  = 240;
   localparam int X_BITS = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   direcc_xy_escalado_if #(.COL_W(11), .ROW_W(10), .ADDR_W(17)) if_lin ();
   direcc_xy_escalado_if #(.COL_W(11), .ROW_W(10), .ADDR_W(17)) if_pk ();

   direcc_xy_escalado #(.LINEAR(LIN))  dut_lin (.clk(clk), .rst_n(rst_n), .bus(if_lin));
   direcc_xy_escalado #(.LINEAR(PACK)) dut_pk  (.clk(clk), .rst_n(rst_n), .bus(if_pk));

   int n_checks = 0;
   int n_errors = 0;

   // Model state: scale, ticks since column H_BP, image lines finished, armed.
   int m_s = 1, m_xt = 0, m_lc = 0;
   bit m_armed = 1'b0;
   int e_lin = 0, e_pk = 0;
   bit e_v = 1'b0, e_fs = 1'b0;
   int cur_c = 0, cur_f = 0;

   typedef struct {
      bit nf;
      int sel;
      int c;
      int f;
      int e_lin;
      int e_pk;
      bit e_v;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_s = 1; m_xt = 0; m_lc = 0; m_armed = 1'b0;
      e_lin = 0; e_pk = 0; e_v = 1'b0; e_fs = 1'b0;
   endtask

   task automatic model_step(input int c, input int f, input int sel);
      int hend, vend, x, y;
      bit ci, ri, org;
      hend = H_BP + IMG_W * m_s - 1;
      vend = V_BP + IMG_H * m_s - 1;
      ci  = (c >= H_BP) && (c <= hend);
      ri  = (f >= V_BP) && (f <= vend);
      org = (c == 0) && (f == 0);
      if (c == H_BP) m_xt = 0;
      else if (ci) m_xt++;
      x = m_xt / m_s; if (x > IMG_W - 1) x = IMG_W - 1;
      y = m_lc / m_s; if (y > IMG_H - 1) y = IMG_H - 1;
      e_v   = m_armed && ci && ri;
      e_lin = e_v ? y * IMG_W + x : 0;
      e_pk  = e_v ? y * (1 << X_BITS) + x : 0;
      e_fs  = org;
      if (ri && c == hend) m_lc++;
      if (org) begin
         m_s = (sel == 0) ? 1 : (sel == 2) ? 4 : 2;
         m_armed = 1'b1;
         m_lc = 0;
      end
   endtask

   task automatic tick(input int c, input int f, input int sel, input bit en);
      if_lin.pix_en = en; if_lin.Columnas = 11'(c); if_lin.Filas = 10'(f); if_lin.scale_sel = 2'(sel);
      if_pk.pix_en  = en; if_pk.Columnas  = 11'(c); if_pk.Filas  = 10'(f); if_pk.scale_sel  = 2'(sel);
      if (!rst_n) model_reset();
      else if (en) model_step(c, f, sel);
      @(posedge clk);
      #1;
      chk("addr_lin", 32'(if_lin.Address), 32'(e_lin));
      chk("addr_pk", 32'(if_pk.Address), 32'(e_pk));
      chk("valid_lin", 32'(if_lin.addr_valid), 32'(e_v));
      chk("valid_pk", 32'(if_pk.addr_valid), 32'(e_v));
      chk("frame_start", 32'(if_pk.frame_start), 32'(e_fs));
   endtask

   // Raster walk to (c,f): closes skipped image lines, fills columns before c densely.
   task automatic goto_px(input int c, input int f, input int sel);
      int hend, vend, start, stop;
      hend = H_BP + IMG_W * m_s - 1;
      vend = V_BP + IMG_H * m_s - 1;
      if (f != cur_f) begin
         if (cur_f >= V_BP && cur_f <= vend && cur_c < hend) tick(hend, cur_f, sel, 1'b1);
         for (int r = cur_f + 1; r < f; r++) begin
            if (r >= V_BP && r <= vend) begin
               tick(H_BP, r, sel, 1'b1);
               tick(hend, r, sel, 1'b1);
            end
         end
         start = H_BP;
      end else begin
         start = (cur_c + 1 > H_BP) ? cur_c + 1 : H_BP;
      end
      stop = (c - 1 < hend) ? c - 1 : hend;
      for (int cc = start; cc <= stop; cc++) tick(cc, f, sel, 1'b1);
      tick(c, f, sel, 1'b1);
      cur_c = c;
      cur_f = f;
   endtask

   task automatic new_frame(input int sel);
      tick(0, 0, sel, 1'b1);
      cur_c = 0;
      cur_f = 0;
   endtask

   initial begin
      int hold_a, s, hend, vend, r, k, j;
      if_lin.pix_en = 1'b0; if_lin.Columnas = '0; if_lin.Filas = '0; if_lin.scale_sel = '0;
      if_pk.pix_en  = 1'b0; if_pk.Columnas  = '0; if_pk.Filas  = '0; if_pk.scale_sel  = '0;

      // Reset held mid-line, then window ticks before any frame start stay invalid.
      for (int i = 0; i < 3; i++) tick(400 + i, 50, 0, 1'b1);
      chk("reset_addr", 32'(if_lin.Address), 32'd0);
      chk("reset_valid", 32'(if_lin.addr_valid), 32'd0);
      rst_n = 1'b1;
      for (int cc = 216; cc < 226; cc++) tick(cc, 40, 0, 1'b1);
      chk("unarmed_valid", 32'(if_lin.addr_valid), 32'd0);

      vt.push_back('{1'b1, 1, 216, 35, 0, 0, 1'b1});
      vt.push_back('{1'b0, 1, 218, 35, 1, 1, 1'b1});
      vt.push_back('{1'b0, 1, 855, 36, 319, 319, 1'b1});
      vt.push_back('{1'b0, 1, 216, 37, 320, 512, 1'b1});
      vt.push_back('{1'b0, 1, 855, 514, 76799, 122687, 1'b1});
      vt.push_back('{1'b0, 1, 856, 514, 0, 0, 1'b0});
      vt.push_back('{1'b1, 0, 216, 35, 0, 0, 1'b1});
      vt.push_back('{1'b0, 0, 535, 35, 319, 319, 1'b1});
      vt.push_back('{1'b0, 0, 216, 36, 320, 512, 1'b1});
      vt.push_back('{1'b0, 0, 535, 274, 76799, 122687, 1'b1});
      vt.push_back('{1'b0, 0, 400, 274, 76799, 122687, 1'b1});
      vt.push_back('{1'b0, 0, 536, 274, 0, 0, 1'b0});
      vt.push_back('{1'b1, 2, 216, 35, 0, 0, 1'b1});
      vt.push_back('{1'b0, 2, 1495, 35, 319, 319, 1'b1});
      vt.push_back('{1'b0, 2, 1496, 35, 0, 0, 1'b0});
      vt.push_back('{1'b1, 3, 216, 35, 0, 0, 1'b1});
      vt.push_back('{1'b0, 3, 217, 35, 0, 0, 1'b1});
      vt.push_back('{1'b0, 3, 218, 35, 1, 1, 1'b1});
      vt.push_back('{1'b0, 3, 855, 35, 319, 319, 1'b1});
      vt.push_back('{1'b0, 3, 856, 35, 0, 0, 1'b0});
      vt.push_back('{1'b1, 0, 216, 35, 0, 0, 1'b1});
      vt.push_back('{1'b0, 2, 216, 100, 20800, 33280, 1'b1});
      vt.push_back('{1'b0, 2, 300, 100, 20884, 33364, 1'b1});
      vt.push_back('{1'b0, 2, 536, 100, 0, 0, 1'b0});
      vt.push_back('{1'b1, 2, 1495, 35, 319, 319, 1'b1});

      foreach (vt[i]) begin
         if (vt[i].nf) begin
            new_frame(vt[i].sel);
            chk("tbl_fs", 32'(if_lin.frame_start), 32'd1);
         end
         goto_px(vt[i].c, vt[i].f, vt[i].sel);
         chk("tbl_lin", 32'(if_lin.Address), 32'(vt[i].e_lin));
         chk("tbl_pk", 32'(if_pk.Address), 32'(vt[i].e_pk));
         chk("tbl_valid", 32'(if_lin.addr_valid), 32'(vt[i].e_v));
      end

      // pix_en stalls: frame_start and Address hold, then resume where they left off.
      tick(0, 0, 1, 1'b1);
      tick(5, 0, 1, 1'b0);
      tick(6, 0, 1, 1'b0);
      chk("fs_hold", 32'(if_lin.frame_start), 32'd1);
      cur_c = 0; cur_f = 0;
      goto_px(400, 40, 1);
      chk("pre_stall", 32'(if_lin.Address), 32'd732);
      hold_a = 32'(if_lin.Address);
      for (int i = 0; i < 5; i++) begin
         tick(300 + 40 * i, 41 + i, 0, 1'b0);
         chk("stall_hold", 32'(if_lin.Address), 32'(hold_a));
      end
      goto_px(401, 40, 1);
      chk("post_stall_a", 32'(if_lin.Address), 32'd732);
      goto_px(402, 40, 1);
      chk("post_stall_b", 32'(if_lin.Address), 32'd733);
      chk("post_stall_fs", 32'(if_lin.frame_start), 32'd0);

      // Reset mid-frame: nothing is addressed until the next frame start.
      new_frame(0);
      goto_px(300, 60, 0);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) tick(301 + i, 60, 0, 1'b1);
      chk("midreset_addr", 32'(if_lin.Address), 32'd0);
      rst_n = 1'b1;
      for (int cc = 216; cc < 231; cc++) tick(cc, 61, 0, 1'b1);
      chk("midreset_valid", 32'(if_pk.addr_valid), 32'd0);
      new_frame(1);
      goto_px(218, 35, 1);
      chk("rearm_addr", 32'(if_lin.Address), 32'd1);
      chk("rearm_valid", 32'(if_lin.addr_valid), 32'd1);

      // Randomised frames: sparse rows, jumps, stalls and mid-frame scale_sel noise.
      for (int fr = 0; fr < 6; fr++) begin
         new_frame($urandom_range(0, 3));
         s = m_s;
         hend = H_BP + IMG_W * s - 1;
         vend = V_BP + IMG_H * s - 1;
         r = V_BP - 2;
         while (r <= vend + 2) begin
            tick(H_BP - 1, r, $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
            tick(H_BP, r, $urandom_range(0, 3), 1'b1);
            k = $urandom_range(0, 20);
            for (int cc = H_BP + 1; cc <= H_BP + k; cc++)
               tick(cc, r, $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
            j = $urandom_range(H_BP, hend + 2);
            tick(j, r, $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
            tick(hend, r, $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
            tick(hend + 1, r, $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 4) == 0) tick(0, r, $urandom_range(0, 3), 1'b1);
            r += $urandom_range(1, (IMG_H * s) / 8);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
